// File: rtl/tp_ntt_loader_if.sv
// Host-side bundle for tp_ntt_loader: command, twiddle and coefficient streams.
// Latency: none, this is wiring only.
// Backpressure: each stream uses valid/ready; the loader drives the ready lines.
interface tp_ntt_loader_if #(
  parameter int TP   = 8,
  parameter int LOGQ = 32
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [LOGQ-1:0]          cmd_q;
  logic                     tw_valid;
  logic                     tw_ready;
  logic [(TP-1)*LOGQ-1:0]   tw_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [TP*LOGQ-1:0]       in_data;

  // Host side: offers commands and data.
  modport master (
    output cmd_valid, cmd_op, cmd_q, tw_valid, tw_data, in_valid, in_data,
    input  cmd_ready, tw_ready, in_ready
  );

  // Loader side: consumes commands and data.
  modport slave (
    input  cmd_valid, cmd_op, cmd_q, tw_valid, tw_data, in_valid, in_data,
    output cmd_ready, tw_ready, in_ready
  );
endinterface

// File: rtl/tp_ntt_loader.sv
// Sequencer turning host command/twiddle/coefficient streams into the NTT stage's cycle-exact inputs.
// Latency: OP_TYPE_OUT 1 cycle after command accept; TWIDDLE_OUT 1 cycle after beat; first NTT word 2 cycles after frame completes.
// Backpressure: the stage has none, so twiddle gaps are zero-filled (tw_err) and coefficients are held in a ping-pong buffer.
module tp_ntt_loader #(
  parameter int N          = 128,
  parameter int TP         = 8,
  parameter int LOGQ       = 32,
  parameter int ITER_PARTS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tp_ntt_loader_if.slave         host,
  output logic [1:0]             OP_TYPE_OUT,
  output logic                   START_NTT,
  output logic [LOGQ-1:0]        Q_OUT,
  output logic [(TP-1)*LOGQ-1:0] TWIDDLE_OUT,
  output logic [TP*LOGQ-1:0]     NTT_OUT,
  output logic                   frame_sync,
  output logic                   tw_err,
  output logic                   running
);
  localparam int D   = N / TP;
  localparam int W   = ITER_PARTS * D;
  localparam int PW  = $clog2(D);
  localparam int TCW = $clog2(W);
  localparam logic [PW-1:0]  PTR_LAST = PW'(D - 1);
  localparam logic [TCW-1:0] TW_LAST  = TCW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_Q, S_QWAIT, S_TWREQ, S_TWBURST, S_TWWAIT, S_START, S_RUN
  } state_t;

  state_t         state;
  logic [TCW-1:0] tw_cnt;
  logic [1:0]     wait_cnt;

  logic [TP*LOGQ-1:0] mem [2][D];
  logic               fill_bank;
  logic               drain_bank;
  logic               burst_act;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [1:0]         full;
  logic               in_fire;

  // Start is signalled through OP_TYPE_OUT, never through the dedicated pin.
  assign START_NTT = 1'b0;

  // Coefficients are only taken once running, and only into a bank that is not awaiting drain.
  assign host.in_ready = running && !full[fill_bank];
  assign in_fire       = host.in_valid && host.in_ready;

  // Command sequencer: all stage-facing controls are registered on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      host.cmd_ready <= 1'b1;
      host.tw_ready  <= 1'b0;
      OP_TYPE_OUT   <= 2'd0;
      Q_OUT         <= '0;
      TWIDDLE_OUT   <= '0;
      tw_err        <= 1'b0;
      running       <= 1'b0;
      tw_cnt        <= '0;
      wait_cnt      <= '0;
    end else begin
      OP_TYPE_OUT <= 2'd0;
      TWIDDLE_OUT <= '0;
      case (state)
        S_IDLE: begin
          if (host.cmd_valid) begin
            case (host.cmd_op)
              2'd1: begin
                state          <= S_Q;
                OP_TYPE_OUT    <= 2'd3;
                Q_OUT          <= host.cmd_q;
                host.cmd_ready <= 1'b0;
              end
              2'd2: begin
                state          <= S_TWREQ;
                OP_TYPE_OUT    <= 2'd1;
                host.cmd_ready <= 1'b0;
                host.tw_ready  <= 1'b1;
                tw_cnt         <= '0;
              end
              2'd3: begin
                state          <= S_START;
                OP_TYPE_OUT    <= 2'd2;
                host.cmd_ready <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_Q: begin
          state    <= S_QWAIT;
          wait_cnt <= 2'd2;
        end
        S_QWAIT, S_TWWAIT: begin
          if (wait_cnt == 2'd0) begin
            state          <= S_IDLE;
            host.cmd_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_TWREQ, S_TWBURST: begin
          // Every cycle here is a ready cycle; a missing word becomes zero so the stage never stalls.
          TWIDDLE_OUT <= host.tw_valid ? host.tw_data : '0;
          if (!host.tw_valid) tw_err <= 1'b1;
          if (tw_cnt == TW_LAST) begin
            state         <= S_TWWAIT;
            host.tw_ready <= 1'b0;
            wait_cnt      <= 2'd1;
          end else begin
            state  <= S_TWBURST;
            tw_cnt <= tw_cnt + 1'b1;
          end
        end
        S_START: begin
          state   <= S_RUN;
          running <= 1'b1;
        end
        S_RUN: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Frame storage; contents are qualified by the full flags, so no reset is needed.
  always_ff @(posedge clk) begin
    if (in_fire) mem[fill_bank][wr_ptr] <= host.in_data;
  end

  // Ping-pong control: fill one bank while the other drains as a gap-free burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_bank  <= 1'b0;
      drain_bank <= 1'b0;
      burst_act  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      full       <= 2'b00;
      NTT_OUT    <= '0;
      frame_sync <= 1'b0;
    end else begin
      NTT_OUT    <= '0;
      frame_sync <= 1'b0;
      if (in_fire) begin
        if (wr_ptr == PTR_LAST) begin
          full[fill_bank] <= 1'b1;
          fill_bank       <= ~fill_bank;
          wr_ptr          <= '0;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      // The fill bank is never full, so this clear never targets the bank set above.
      if (burst_act) begin
        NTT_OUT <= mem[drain_bank][rd_ptr];
        if (rd_ptr == PTR_LAST) begin
          full[drain_bank] <= 1'b0;
          drain_bank       <= ~drain_bank;
          burst_act        <= 1'b0;
          rd_ptr           <= '0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end else if (running && full[drain_bank]) begin
        NTT_OUT    <= mem[drain_bank][0];
        frame_sync <= 1'b1;
        burst_act  <= 1'b1;
        rd_ptr     <= PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_tp_ntt_loader.sv
// Self-checking bench for tp_ntt_loader: command timing, twiddle bursts, framed coefficient bursts, async reset.
`timescale 1ns/1ps
module tb_tp_ntt_loader;
  localparam int N = 128, TP = 8, LOGQ = 32, ITER_PARTS = 3;
  localparam int D = N / TP, W = ITER_PARTS * D;
  localparam int TWW = (TP - 1) * LOGQ, CW = TP * LOGQ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] op_type;
  logic start_ntt;
  logic [LOGQ-1:0] q_out;
  logic [TWW-1:0] tw_out;
  logic [CW-1:0] ntt_out;
  logic frame_sync, tw_err, running;

  int total = 0;
  int bad = 0;

  // Coefficient model: accepted words in order, frame ready times, burst progress.
  logic [CW-1:0] coef_q[$];
  int ready_at[$];
  int t = 0, words_in = 0, freed = 0, burst_pos = 0, frames_started = 0, held = 0;

  tp_ntt_loader_if #(.TP(TP), .LOGQ(LOGQ)) bus ();

  tp_ntt_loader #(.N(N), .TP(TP), .LOGQ(LOGQ), .ITER_PARTS(ITER_PARTS)) dut (
    .clk(clk), .rst_n(rst_n), .host(bus),
    .OP_TYPE_OUT(op_type), .START_NTT(start_ntt), .Q_OUT(q_out),
    .TWIDDLE_OUT(tw_out), .NTT_OUT(ntt_out),
    .frame_sync(frame_sync), .tw_err(tw_err), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] rand_cw();
    logic [CW-1:0] r;
    for (int i = 0; i < CW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [TWW-1:0] rand_tw();
    logic [TWW-1:0] r;
    for (int i = 0; i < TWW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_reset(input string p);
    chk({p, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({p, "_tw_ready"}, bus.tw_ready, 0);
    chk({p, "_in_ready"}, bus.in_ready, 0);
    chk({p, "_op_type"}, op_type, 0);
    chk({p, "_start_ntt"}, start_ntt, 0);
    chk({p, "_frame_sync"}, frame_sync, 0);
    chk({p, "_tw_err"}, tw_err, 0);
    chk({p, "_running"}, running, 0);
    chk({p, "_q_out"}, q_out, 0);
    chk({p, "_twiddle_out"}, tw_out, 0);
    chk({p, "_ntt_out"}, ntt_out, 0);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after acceptance.
  task automatic send_cmd(input logic [1:0] op, input logic [LOGQ-1:0] q);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_q     = q;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_q     = $urandom;
  endtask

  task automatic tw_load(input int drop, input string p);
    logic [TWW-1:0] words [W];
    logic [TWW-1:0] exp_out, cur;
    logic cur_v;
    int rc, first_rc, last_rc, extra_op, back;
    for (int i = 0; i < W; i++) words[i] = rand_tw();
    exp_out = '0; rc = 0; first_rc = -1; last_rc = -1; extra_op = 0; back = -1;
    bus.in_valid = 1'b1;
    bus.in_data  = rand_cw();
    send_cmd(2'd2, $urandom);
    for (int c = 0; c < W + 6; c++) begin
      cur_v = (rc < W) && (rc != drop);
      if (cur_v) cur = words[rc];
      else cur = rand_tw();
      bus.tw_valid = cur_v;
      bus.tw_data  = cur;
      @(negedge clk);
      chk($sformatf("%s_twiddle_c%0d", p, c), tw_out, exp_out);
      if (c == 0) chk({p, "_op_type"}, op_type, 1);
      else if (op_type != 2'd0) extra_op++;
      if (c == 5) chk({p, "_in_ready_before_run"}, bus.in_ready, 0);
      if (bus.tw_ready) begin
        if (first_rc < 0) first_rc = c;
        last_rc = c;
        rc++;
        exp_out = cur_v ? cur : '0;
      end else begin
        exp_out = '0;
      end
      if (bus.cmd_ready && back < 0) back = c;
      @(posedge clk); #1;
    end
    bus.tw_valid = 1'b0;
    bus.in_valid = 1'b0;
    chk({p, "_ready_count"}, rc, W);
    chk({p, "_ready_span"}, last_rc - first_rc + 1, W);
    chk({p, "_ready_first"}, first_rc, 0);
    chk({p, "_extra_op"}, extra_op, 0);
    chk({p, "_cmd_ready_back"}, back, W + 2);
  endtask

  // Per-cycle expectation for NTT_OUT/frame_sync derived from accepted frames.
  task automatic check_outputs();
    if (burst_pos > 0) begin
      chk($sformatf("ntt_sync_mid_f%0d_w%0d", frames_started - 1, burst_pos), frame_sync, 0);
      chk($sformatf("ntt_word_f%0d_w%0d", frames_started - 1, burst_pos), ntt_out, coef_q.pop_front());
      burst_pos++;
      if (burst_pos == D) begin
        burst_pos = 0;
        freed++;
      end
    end else if (ready_at.size() > 0 && ready_at[0] <= t) begin
      chk($sformatf("ntt_sync_f%0d", frames_started), frame_sync, 1);
      chk($sformatf("ntt_word_f%0d_w0", frames_started), ntt_out, coef_q.pop_front());
      void'(ready_at.pop_front());
      frames_started++;
      burst_pos = 1;
    end else begin
      chk("ntt_idle_sync", frame_sync, 0);
      chk("ntt_idle_zero", ntt_out, 0);
    end
  endtask

  task automatic run_stream(input int nwords, input int pct, input int stop_pos,
                            input int max_cyc, output bit done);
    int sent;
    bit drained;
    sent = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      bus.in_valid = (sent < nwords) && ($urandom_range(99) < pct);
      bus.in_data  = rand_cw();
      @(negedge clk);
      t++;
      check_outputs();
      held = words_in / D - freed;
      if (held == 2) chk("in_ready_both_full", bus.in_ready, 0);
      else if (held == 0) chk("in_ready_empty", bus.in_ready, 1);
      if (bus.in_valid && bus.in_ready) begin
        coef_q.push_back(bus.in_data);
        words_in++;
        sent++;
        if (words_in % D == 0) ready_at.push_back(t + 2);
      end
      if (stop_pos > 0 && burst_pos == stop_pos) begin
        done = 1'b1;
        return;
      end
      drained = (stop_pos == 0) && (sent == nwords) && (burst_pos == 0) &&
                (ready_at.size() == 0) && (coef_q.size() == 0);
      @(posedge clk); #1;
      if (drained) begin
        done = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bit done;
    int n_op, first_op, low, back;
    logic [1:0] op_seen;
    logic [LOGQ-1:0] q2;

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_q = '0;
    bus.tw_valid = 1'b0; bus.tw_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("rel");
    @(posedge clk); #1;

    // Q load.
    send_cmd(2'd1, 32'h3001);
    n_op = 0; first_op = -1; low = 0; back = -1; op_seen = 2'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (op_type != 2'd0) begin
        n_op++;
        if (first_op < 0) first_op = c;
        op_seen = op_type;
      end
      if (back < 0) begin
        if (bus.cmd_ready == 1'b0) low++;
        else back = c;
      end
      if (c == 0) chk("q_out_next_cycle", q_out, 32'h3001);
      @(posedge clk); #1;
    end
    chk("q_op_count", n_op, 1);
    chk("q_op_cycle", first_op, 0);
    chk("q_op_value", op_seen, 3);
    chk("q_ready_low_cycles", low, 4);
    chk("q_out_held", q_out, 32'h3001);

    // Twiddle loads: clean, then with beat 10 missing.
    tw_load(-1, "tw_clean");
    chk("tw_err_clean", tw_err, 0);
    tw_load(10, "tw_drop");
    chk("tw_err_drop", tw_err, 1);

    // Start.
    send_cmd(2'd3, '0);
    @(negedge clk);
    chk("start_op", op_type, 2);
    chk("start_cmd_ready", bus.cmd_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("run_running", running, 1);
    chk("run_op_idle", op_type, 0);
    chk("run_in_ready", bus.in_ready, 1);
    chk("run_start_ntt", start_ntt, 0);
    @(posedge clk); #1;

    // Commands are ignored once running.
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_q = 32'hdead_beef;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("run_ignore_op_c%0d", c), op_type, 0);
      chk($sformatf("run_ignore_ready_c%0d", c), bus.cmd_ready, 0);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    chk("run_ignore_q_held", q_out, 32'h3001);

    // Three frames with a ragged host, then three at full rate (back-to-back bursts).
    run_stream(3 * D, 60, 0, 400, done);
    chk("stream_random_done", done, 1);
    chk("stream_random_frames", frames_started, 3);
    run_stream(3 * D, 100, 0, 200, done);
    chk("stream_fast_done", done, 1);
    chk("stream_fast_frames", frames_started, 6);
    chk("tw_err_sticky", tw_err, 1);

    // Async reset in the middle of a burst, just after word 7 appears.
    run_stream(D, 100, 8, 100, done);
    chk("stream_reset_reached_w7", done, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    coef_q.delete();
    ready_at.delete();
    burst_pos = 0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("async_rel");
    @(posedge clk); #1;
    q2 = $urandom;
    send_cmd(2'd1, q2);
    @(negedge clk);
    chk("post_reset_q_op", op_type, 3);
    chk("post_reset_q_out", q_out, q2);
    chk("post_reset_ntt_zero", ntt_out, 0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tp_ntt_loader.md
# tp_ntt_loader

Host-side sequencer sitting directly upstream of the first TP-NTT block stage. It converts three host interfaces into the exact cycle-contiguous control and data sequence the NTT stage requires: a command channel, a twiddle stream and a coefficient stream, each with valid/ready.
- Commands are load modulus, load twiddles and start.
- The stage has no backpressure and no input valid, so coefficients are staged in a ping-pong frame buffer and emitted as gap-free bursts of N/TP words.

## Interface
- N, 128: polynomial length.
- TP, 8: coefficients per word; power of two.
- LOGQ, 32: coefficient width.
- ITER_PARTS, 3: twiddle parts per load; a twiddle burst is ITER_PARTS*N/TP words.
- clk in 1: clock; all state changes on rising edge.
- rst_n in 1: reset, asynchronous, active-low.
- cmd_valid in 1, cmd_ready out 1, cmd_op in 2: command handshake. cmd_op encoding: 1 = Q load, 2 = twiddle load, 3 = start; 0 is ignored and consumed.
- cmd_q in LOGQ: modulus, sampled with a Q-load command.
- tw_valid in 1, tw_ready out 1, tw_data in (TP-1)*LOGQ: twiddle stream.
- in_valid in 1, in_ready out 1, in_data in TP*LOGQ: coefficient stream, one word per beat.
- OP_TYPE_OUT out 2: to the stage's OP_TYPE_INPUT.
- START_NTT out 1: tied 0; start is issued via OP_TYPE_OUT=2.
- Q_OUT out LOGQ: to the stage's Q_in.
- TWIDDLE_OUT out (TP-1)*LOGQ: to the stage's TWIDDLE_INPUT.
- NTT_OUT out TP*LOGQ: to the stage's NTT_INPUT.
- frame_sync out 1: pulse coincident with the first NTT_OUT word of each burst.
- tw_err out 1: sticky twiddle-underflow flag.
- running out 1: high from S_RUN onward.

## Operation
- Derived constants: D = N/TP; W = ITER_PARTS*D.
- States and transitions:
  - S_IDLE: cmd_ready=1. On an accepted command: op1 → S_Q; op2 → S_TWREQ; op3 → S_START; op0 → stay.
  - S_Q: OP_TYPE_OUT=3 for 1 cycle; Q_OUT <= cmd_q, latched at command accept and then held indefinitely → S_QWAIT.
  - S_QWAIT: 3 cycles, covering the stage's 2-cycle Q-load plus its return to idle → S_IDLE.
  - S_TWREQ: OP_TYPE_OUT=1 for 1 cycle, with tw_ready=1 in this same cycle → S_TWBURST.
  - S_TWBURST: tw_ready=1 for cycles 1..W-1 of the burst (W ready cycles total, counting S_TWREQ). Counter tw_cnt runs 0..W-1 → S_TWWAIT.
  - S_TWWAIT: 2 cycles → S_IDLE.
  - S_START: OP_TYPE_OUT=2 for 1 cycle → S_RUN.
  - S_RUN: terminal. cmd_ready=0 until reset; commands are never accepted.
- Twiddle data path:
  - TWIDDLE_OUT is registered: the word accepted on ready-cycle k appears one cycle later.
  - If tw_valid=0 on a ready cycle: zero is substituted, tw_err is set, and the burst still completes at W cycles with no stall.
  - TWIDDLE_OUT = 0 outside the burst.
- OP_TYPE_OUT = 0 in every state not listed above.
- Coefficient buffer: two banks (A, B), each D × TP*LOGQ, with a full flag per bank.
  - Fill:
    - The write pointer fills the current fill bank on in_valid&&in_ready.
    - After D beats the bank is marked full and filling switches to the other bank.
    - in_ready = running && fill bank not full.
  - Drain:
    - In S_RUN, when no burst is active and the drain bank is full, a burst starts.
    - A burst outputs D consecutive words, index 0..D-1, on NTT_OUT (registered).
    - At the end of the burst the bank is cleared and drain switches to the other bank.
  - A bank freed at the end of a burst may be refilled starting the next cycle.
  - Back-to-back bursts: if the other bank is already full when a burst ends, the next burst begins on the immediately following cycle, with no gap.
  - NTT_OUT = 0 whenever no burst is active.
- in_ready = 0 before S_RUN; coefficients cannot be preloaded.

## Timing
- Reset values (all outputs):
  - cmd_ready=1, tw_ready=0, in_ready=0.
  - OP_TYPE_OUT=0, START_NTT=0, frame_sync=0, tw_err=0, running=0.
  - Q_OUT=0, TWIDDLE_OUT=0, NTT_OUT=0.
  - All pointers, counters and full flags 0.
- Reset mid-operation: an asynchronous assertion returns to S_IDLE immediately and discards buffered frames.
- Command accept at edge E:
  - OP_TYPE_OUT nonzero during cycle E+1 only.
  - Twiddle word k appears on TWIDDLE_OUT at E+2+k.
  - cmd_ready returns to 1 at E+1+W+2 (twiddle load) or E+1+1+3 (Q load).
- Coefficient latency: the D-th beat of a bank is accepted at edge F; frame_sync and word 0 appear at F+2 if the drain side is idle.
- Simultaneous cases:
  - The last fill beat and the end of a burst on the same edge are both honoured.
  - Same-edge full-flag set and clear target different banks, so no conflict.

## Test plan
- Reset then Q load with cmd_q=0x3001: OP_TYPE_OUT=3 for exactly 1 cycle; Q_OUT=0x3001 from the next cycle; cmd_ready=0 for 4 cycles.
- Twiddle load, N=128/TP=8/ITER_PARTS=3:
  - tw_ready high for exactly 48 consecutive cycles.
  - Words 0..47 appear in order one cycle after acceptance.
  - tw_err=0.
- Twiddle load with tw_valid dropped on beat 10: word 10 is zero, burst length is still 48, tw_err=1 and stays set until reset.
- Start, then stream 3 frames of 16 words each, with in_valid randomly toggling:
  - Each frame is emitted as exactly 16 gap-free words in order, frame_sync on word 0.
  - NTT_OUT=0 between bursts.
- Host fills both banks before the first burst ends: in_ready=0 while both are full; the second burst follows the first with no idle cycle.
- rst_n asserted mid-burst (word 7): all outputs return to reset values asynchronously; commands are accepted again after release.
